servile_byte_wb_initiator: RTL and testbench

Byte-to-word Wishbone initiator: accepts a stream of byte-wide read/write requests and issues 32-bit Wishbone cycles with the correct byte selects. Consecutive byte writes to the same word merge in a one-word write-combining buffer, which is emitted as a single masked Wishbone write. It sits between byte-serial agents (debug loaders, byte-wide DMA) and the word-wide Wishbone port of the shared RF/memory SRAM arbiter.

---
 rtl/servile_byte_wb_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_servile_byte_wb_initiator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_byte_wb_initiator.sv
// Byte-to-word Wishbone initiator with a one-word write-combining buffer.
// Byte writes to the same word merge into the buffer and leave as one masked
// Wishbone write; reads always drain the buffer first so they never pass a
// buffered write. All Wishbone outputs come straight from flops.
//
// Request handshake: a request transfers on a rising clock edge where both
// i_req_valid and o_req_ready are high; the agent holds address, data and
// we stable while valid is high and ready is low.
module servile_byte_wb_initiator #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_req_adr,
  input  logic [7:0]    i_req_dat,
  input  logic          i_req_we,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_flush,
  output logic [7:0]    o_rsp_dat,
  output logic          o_rsp_valid,
  output logic          o_idle,
  output logic [AW-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-3:0] buf_adr_q, buf_adr_d;
  logic [31:0]   buf_dat_q, buf_dat_d;
  logic [3:0]    buf_sel_q, buf_sel_d;
  logic [1:0]    rd_lane_q, rd_lane_d;
  logic [AW-3:0] wb_adr_q, wb_adr_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic [3:0]    wb_sel_q, wb_sel_d;
  logic          wb_we_q, wb_we_d;
  logic          wb_stb_q, wb_stb_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic          buf_valid;
  logic          flush_needed;
  logic          req_ready;
  logic [AW-3:0] req_word;
  logic [1:0]    req_lane;
  logic [3:0]    merged_sel;
  logic [31:0]   merged_dat;

  // Zero the data of lanes that are not selected.
  function automatic logic [31:0] mask_lanes(input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = dat[8*b +: 8] & {8{sel[b]}};
    end
    return res;
  endfunction

  assign buf_valid = |buf_sel_q;
  assign req_word  = i_req_adr[AW-1:2];
  assign req_lane  = i_req_adr[1:0];

  // Buffered word must leave before anything else: full, forced, or a
  // request that cannot merge (any read, or a write to another word).
  assign flush_needed = buf_valid &
                        ((buf_sel_q == 4'hF) | i_flush |
                         (i_req_valid & (!i_req_we | (req_word != buf_adr_q))));

  // Buffer contents as they would be after merging the current write.
  always_comb begin
    merged_sel = buf_sel_q;
    merged_dat = buf_dat_q;
    merged_sel[req_lane] = 1'b1;
    merged_dat[8*req_lane +: 8] = i_req_dat;
  end

  // Next-state, buffer and registered-output logic.
  always_comb begin
    state_d     = state_q;
    buf_adr_d   = buf_adr_q;
    buf_dat_d   = buf_dat_q;
    buf_sel_d   = buf_sel_q;
    rd_lane_d   = rd_lane_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_sel_d    = wb_sel_q;
    wb_we_d     = wb_we_q;
    wb_stb_d    = wb_stb_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_valid_d = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_needed) begin
          state_d  = WRITE;
          wb_adr_d = buf_adr_q;
          wb_dat_d = mask_lanes(buf_dat_q, buf_sel_q);
          wb_sel_d = buf_sel_q;
          wb_we_d  = 1'b1;
          wb_stb_d = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (i_req_valid && i_req_we) begin
            buf_adr_d = req_word;
            buf_dat_d = merged_dat;
            buf_sel_d = merged_sel;
            // A write completing the word goes out on the next cycle.
            if (merged_sel == 4'hF) begin
              state_d  = WRITE;
              wb_adr_d = req_word;
              wb_dat_d = merged_dat;
              wb_sel_d = 4'hF;
              wb_we_d  = 1'b1;
              wb_stb_d = 1'b1;
            end
          end else if (i_req_valid) begin
            state_d   = READ;
            rd_lane_d = req_lane;
            wb_adr_d  = req_word;
            wb_dat_d  = 32'h0;
            wb_sel_d  = 4'hF;
            wb_we_d   = 1'b0;
            wb_stb_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (i_wb_ack) begin
          state_d   = IDLE;
          buf_sel_d = 4'h0;
          buf_dat_d = 32'h0;
          wb_stb_d  = 1'b0;
          wb_we_d   = 1'b0;
        end
      end
      READ: begin
        if (i_wb_ack) begin
          state_d     = IDLE;
          rsp_dat_d   = i_wb_rdt[8*rd_lane_q +: 8];
          rsp_valid_d = 1'b1;
          wb_stb_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, buffer and output registers; reset discards any buffered data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      buf_adr_q   <= '0;
      buf_dat_q   <= '0;
      buf_sel_q   <= '0;
      rd_lane_q   <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_sel_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_stb_q    <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_adr_q   <= buf_adr_d;
      buf_dat_q   <= buf_dat_d;
      buf_sel_q   <= buf_sel_d;
      rd_lane_q   <= rd_lane_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_sel_q    <= wb_sel_d;
      wb_we_q     <= wb_we_d;
      wb_stb_q    <= wb_stb_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready = req_ready & i_rst_n;
  assign o_idle      = (state_q == IDLE) & !buf_valid;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_stb    = wb_stb_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_servile_byte_wb_initiator.sv
// Bench for servile_byte_wb_initiator: directed byte requests, a Wishbone
// responder with programmable ack delay, and scoreboards for bus cycles and
// read responses.
module tb_servile_byte_wb_initiator;

  localparam int W = 43; // {we, adr[5:0], sel[3:0], dat[31:0]}

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_req_adr;
  logic [7:0]  i_req_dat;
  logic        i_req_we;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_flush;
  logic [7:0]  o_rsp_dat;
  logic        o_rsp_valid;
  logic        o_idle;
  logic [5:0]  o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic [1:0]  o_dbg_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   rsp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  logic        slave_en = 1'b1;
  logic [31:0] rdt_val = 32'h0;

  servile_byte_wb_initiator #(.AW(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_adr   (i_req_adr),
    .i_req_dat   (i_req_dat),
    .i_req_we    (i_req_we),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_flush     (i_flush),
    .o_rsp_dat   (o_rsp_dat),
    .o_rsp_valid (o_rsp_valid),
    .o_idle      (o_idle),
    .o_wb_adr    (o_wb_adr),
    .o_wb_dat    (o_wb_dat),
    .o_wb_sel    (o_wb_sel),
    .o_wb_we     (o_wb_we),
    .o_wb_stb    (o_wb_stb),
    .i_wb_rdt    (i_wb_rdt),
    .i_wb_ack    (i_wb_ack),
    .o_dbg_state (o_dbg_state)
  );

  // Clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [W-1:0] pack(input logic we, input logic [5:0] adr,
                                        input logic [3:0] sel, input logic [31:0] dat);
    return {we, adr, sel, dat};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone responder and bus-cycle monitor
  initial begin
    int  wait_cnt;
    logic last_read;
    wait_cnt  = 0;
    last_read = 1'b0;
    i_wb_ack  = 1'b0;
    i_wb_rdt  = 32'h0;
    forever begin
      @(negedge i_clk);
      if (i_wb_ack) begin
        i_wb_ack = 1'b0;
        check("stb_drop_after_ack", {63'd0, o_wb_stb}, 64'd0);
        if (last_read) check("rsp_valid_at_ack_plus1", {63'd0, o_rsp_valid}, 64'd1);
      end else if (o_wb_stb && slave_en) begin
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cycle actual=%0h expected=none at %0t",
                     pack(o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat), $time);
          end else begin
            check("wb_cycle", {21'd0, pack(o_wb_we, o_wb_adr, o_wb_sel,
                                           o_wb_we ? o_wb_dat : 32'h0)},
                  {21'd0, exp_q.pop_front()});
          end
          last_read = !o_wb_we;
          i_wb_rdt  = rdt_val;
          i_wb_ack  = 1'b1;
          wait_cnt  = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Read-response monitor
  initial begin
    logic prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        if (prev_rv) begin
          checks++;
          errors++;
          $display("FAIL rsp_pulse_len actual=2+ expected=1 at %0t", $time);
        end else if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%0h expected=none at %0t", o_rsp_dat, $time);
        end else begin
          check("rsp_dat", {56'd0, o_rsp_dat}, {56'd0, rsp_q.pop_front()});
        end
      end
      prev_rv = o_rsp_valid;
    end
  end

  // Driver: present one request and hold it until accepted.
  task automatic send_req(input logic [7:0] adr, input logic [7:0] dat, input logic we);
    int n;
    n = 0;
    @(negedge i_clk);
    i_req_adr   = adr;
    i_req_dat   = dat;
    i_req_we    = we;
    i_req_valid = 1'b1;
    #1;
    while (!o_req_ready && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (!o_req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=not_ready expected=ready adr=%0h", adr);
    end else begin
      @(posedge i_clk);
    end
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
  endtask

  // Wait until every expected bus cycle and response has been seen.
  task automatic drain();
    int n;
    n = 0;
    @(negedge i_clk);
    while ((exp_q.size() != 0 || rsp_q.size() != 0 || o_wb_stb) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=exp%0d_rsp%0d expected=0_0", exp_q.size(), rsp_q.size());
    end
  endtask

  // Directed sequence
  initial begin
    i_rst_n     = 1'b0;
    i_req_adr   = 8'h0;
    i_req_dat   = 8'h0;
    i_req_we    = 1'b0;
    i_req_valid = 1'b0;
    i_flush     = 1'b0;
    #12;
    check("rst_stb",   {63'd0, o_wb_stb},    64'd0);
    check("rst_sel",   {60'd0, o_wb_sel},    64'd0);
    check("rst_ready", {63'd0, o_req_ready}, 64'd0);
    check("rst_idle",  {63'd0, o_idle},      64'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", {63'd0, o_req_ready}, 64'd1);

    // Four back-to-back byte writes fill one word.
    exp_q.push_back(pack(1'b1, 6'h10, 4'hF, 32'h44332211));
    send_req(8'h40, 8'h11, 1'b1);
    send_req(8'h41, 8'h22, 1'b1);
    send_req(8'h42, 8'h33, 1'b1);
    send_req(8'h43, 8'h44, 1'b1);
    check("full_word_stb_next", {63'd0, o_wb_stb}, 64'd1);
    drain();
    check("idle_after_full", {63'd0, o_idle}, 64'd1);

    // Read flushes the buffered write first; lane 0 of the read word.
    exp_q.push_back(pack(1'b1, 6'h10, 4'h2, 32'h0000AB00));
    exp_q.push_back(pack(1'b0, 6'h08, 4'hF, 32'h0));
    rsp_q.push_back(8'hEF);
    rdt_val = 32'hDEADBEEF;
    send_req(8'h41, 8'hAB, 1'b1);
    send_req(8'h20, 8'h00, 1'b0);
    check("read_stb_next", {63'd0, o_wb_stb}, 64'd1);
    drain();

    // Write to a different word flushes the first; second stays buffered.
    exp_q.push_back(pack(1'b1, 6'h02, 4'h1, 32'h00000005));
    send_req(8'h08, 8'h05, 1'b1);
    send_req(8'h0C, 8'h06, 1'b1);
    drain();
    check("buffer_held_not_idle", {63'd0, o_idle}, 64'd0);
    exp_q.push_back(pack(1'b1, 6'h03, 4'h1, 32'h00000006));
    pulse_flush();
    drain();

    // Read with a delayed ack: top lane.
    ack_delay = 3;
    rdt_val   = 32'h12345678;
    exp_q.push_back(pack(1'b0, 6'h01, 4'hF, 32'h0));
    rsp_q.push_back(8'h12);
    send_req(8'h07, 8'h00, 1'b0);
    check("delayed_read_stb", {63'd0, o_wb_stb}, 64'd1);
    drain();
    ack_delay = 0;

    // Explicit flush of a single lane; flush of empty buffer does nothing.
    exp_q.push_back(pack(1'b1, 6'h00, 4'h4, 32'h007F0000));
    send_req(8'h02, 8'h7F, 1'b1);
    pulse_flush();
    drain();
    pulse_flush();
    repeat (3) @(negedge i_clk);
    check("empty_flush_no_stb", {63'd0, o_wb_stb}, 64'd0);
    check("empty_flush_idle",   {63'd0, o_idle},   64'd1);

    // Flush and a mergeable write in the same cycle: flush wins.
    exp_q.push_back(pack(1'b1, 6'h0C, 4'h1, 32'h00000055));
    send_req(8'h30, 8'h55, 1'b1);
    @(negedge i_clk);
    i_flush     = 1'b1;
    i_req_adr   = 8'h31;
    i_req_dat   = 8'h66;
    i_req_we    = 1'b1;
    i_req_valid = 1'b1;
    #1;
    check("flush_wins_ready", {63'd0, o_req_ready}, 64'd0);
    @(negedge i_clk);
    i_flush     = 1'b0;
    i_req_valid = 1'b0;
    exp_q.push_back(pack(1'b1, 6'h0C, 4'h2, 32'h00006600));
    send_req(8'h31, 8'h66, 1'b1);
    pulse_flush();
    drain();

    // Reset while a write cycle is outstanding.
    slave_en = 1'b0;
    send_req(8'h10, 8'h99, 1'b1);
    pulse_flush();
    check("stb_before_rst", {63'd0, o_wb_stb}, 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_stb",       {63'd0, o_wb_stb},    64'd0);
    check("rst_mid_sel",       {60'd0, o_wb_sel},    64'd0);
    check("rst_mid_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    check("rst_mid_idle",      {63'd0, o_idle},      64'd1);
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    slave_en = 1'b1;
    repeat (4) @(negedge i_clk);
    check("post_rst_no_stb", {63'd0, o_wb_stb}, 64'd0);
    check("post_rst_idle",   {63'd0, o_idle},   64'd1);

    check("exp_q_empty", exp_q.size(), 64'd0);
    check("rsp_q_empty", rsp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
